// File: rtl/ioconfig_pkg.sv
// Shared types and constants for the I/O ring configuration loader.
// Optional even-parity check on the data stream: IOCONFIG_PARITY_EN.
package ioconfig_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LOAD,
    PARITY,
    COMMIT,
    ERR
  } state_t;

  localparam int CFG_BITS_PER_IO = 3;

  localparam logic [1:0] TS_OFF    = 2'b00;
  localparam logic [1:0] TS_CTRL   = 2'b01;
  localparam logic [1:0] TS_ON     = 2'b10;
  localparam logic [1:0] TS_ON_ALT = 2'b11;

  localparam logic [7:0] DEF_SYNC_WORD = 8'hA5;

  function automatic int cnt_width(
    input int total,
    input int tmo
  );
    int m;
    m = (total > tmo) ? total : tmo;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ioconfig_shift.sv
// Shadow shift register, shared bit counter and running parity
// for the configuration loader.
module ioconfig_shift
  import ioconfig_pkg::*;
#(
  parameter int TOTAL = 30,
  parameter int CW    = 7
) (
  input  logic             IOCLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             cnt_en,
  input  logic             din,
  output logic [TOTAL-1:0] shadow,
  output logic [CW-1:0]    cnt,
  output logic             par
);

  // clear wins over a same-edge shift so sync->load starts clean
  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      shadow <= '0;
      cnt    <= '0;
      par    <= 1'b0;
    end else if (clr) begin
      shadow <= '0;
      cnt    <= '0;
      par    <= 1'b0;
    end else begin
      if (shift_en) begin
        shadow <= {shadow[TOTAL-2:0], din};
        par    <= par ^ din;
      end
      if (cnt_en) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ioconfig_ctrl.sv
// Serial config loader: sync search, shadow load, atomic commit.
// Optional even-parity check on the data stream: IOCONFIG_PARITY_EN.
module ioconfig_ctrl
  import ioconfig_pkg::*;
#(
  parameter int         NUM_IO       = 10,
  parameter logic [7:0] SYNC_WORD    = DEF_SYNC_WORD,
  parameter int         SYNC_TIMEOUT = 64
) (
  input  logic                IOCLK,
  input  logic                RST,
  input  logic                START,
  input  logic                ABORT,
  input  logic                CFG_VALID,
  input  logic                CFG_DATA,
  output logic                CFG_READY,
  output logic [2*NUM_IO-1:0] TSMUX_OUT,
  output logic [NUM_IO-1:0]   DORREG_OUT,
  output logic                BUSY,
  output logic                CFG_DONE,
  output logic                CFG_ERR
);

  localparam int TOTAL = CFG_BITS_PER_IO * NUM_IO;
  localparam int CW    = cnt_width(TOTAL, SYNC_TIMEOUT);

  state_t state, nxt;

  logic [6:0]       sync_q;
  logic [TOTAL-1:0] shadow;
  logic [CW-1:0]    cnt;
  logic             par;
  logic             clr;
  logic             shift_en;
  logic             cnt_en;
  logic             sync_en;
  logic             commit;
  logic             accept;
  logic             done_q;
  logic [2*NUM_IO-1:0] ts_q, ts_nxt;
  logic [NUM_IO-1:0]   dr_q, dr_nxt;

  assign CFG_READY = (state == SYNC) ||
                     (state == LOAD) ||
                     (state == PARITY);
  assign BUSY      = (state != IDLE) && (state != ERR);
  assign CFG_ERR   = (state == ERR);
  assign CFG_DONE  = done_q;
  assign TSMUX_OUT = ts_q;
  assign DORREG_OUT = dr_q;
  assign accept    = CFG_VALID && CFG_READY;

  ioconfig_shift #(
    .TOTAL (TOTAL),
    .CW    (CW)
  ) u_shift (
    .IOCLK    (IOCLK),
    .RST      (RST),
    .clr      (clr),
    .shift_en (shift_en),
    .cnt_en   (cnt_en),
    .din      (CFG_DATA),
    .shadow   (shadow),
    .cnt      (cnt),
    .par      (par)
  );

  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt      = state;
    clr      = 1'b0;
    shift_en = 1'b0;
    cnt_en   = 1'b0;
    sync_en  = 1'b0;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (START) begin
          nxt = SYNC;
          clr = 1'b1;
        end
      end
      SYNC: begin
        if (ABORT) begin
          nxt = IDLE;
        end else if (accept) begin
          cnt_en  = 1'b1;
          sync_en = 1'b1;
          if ({sync_q, CFG_DATA} == SYNC_WORD) begin
            nxt = LOAD;
            clr = 1'b1;
          end else if (cnt == CW'(SYNC_TIMEOUT - 1)) begin
            nxt = ERR;
          end
        end
      end
      LOAD: begin
        if (ABORT) begin
          nxt = IDLE;
        end else if (accept) begin
          shift_en = 1'b1;
          cnt_en   = 1'b1;
          if (cnt == CW'(TOTAL - 1)) begin
`ifdef IOCONFIG_PARITY_EN
            nxt = PARITY;
`else
            nxt = COMMIT;
`endif
          end
        end
      end
      PARITY: begin
        if (ABORT) begin
          nxt = IDLE;
        end else if (accept) begin
          nxt = (CFG_DATA == par) ? COMMIT : ERR;
        end
      end
      COMMIT: begin
        nxt    = IDLE;
        commit = 1'b1;
      end
      ERR: begin
        if (START) begin
          nxt = SYNC;
          clr = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
    end else if (clr) begin
      sync_q <= '0;
    end else if (sync_en) begin
      sync_q <= {sync_q[5:0], CFG_DATA};
    end
  end

  // pad k owns shadow[3k+2:3k]: TSMUX on the upper two, DORREG at 3k
  always_comb begin
    ts_nxt = '0;
    dr_nxt = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      ts_nxt[2*k +: 2] = shadow[3*k+1 +: 2];
      dr_nxt[k]        = shadow[3*k];
    end
  end

  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      ts_q   <= '0;
      dr_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) begin
        ts_q <= ts_nxt;
        dr_q <= dr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ioconfig_ctrl.sv
// Self-checking bench for ioconfig_ctrl with a pad-level reference model.
// Parity scenarios run when IOCONFIG_PARITY_EN is defined.
module tb_ioconfig_ctrl;

  localparam int NUM_IO = 10;
  localparam int TOTAL  = 3 * NUM_IO;

  logic IOCLK = 1'b0;
  logic RST = 1'b1;
  logic START = 1'b0;
  logic ABORT = 1'b0;
  logic CFG_VALID = 1'b0;
  logic CFG_DATA = 1'b0;
  logic CFG_READY;
  logic [2*NUM_IO-1:0] TSMUX_OUT;
  logic [NUM_IO-1:0] DORREG_OUT;
  logic BUSY;
  logic CFG_DONE;
  logic CFG_ERR;

  int errors = 0;
  int checks = 0;

  logic [1:0] pad_ts[NUM_IO];
  logic       pad_dr[NUM_IO];
  bit         stream[$];
  logic [2*NUM_IO-1:0] cur_ts = '0;
  logic [NUM_IO-1:0]   cur_dr = '0;

  ioconfig_ctrl #(
    .NUM_IO       (NUM_IO),
    .SYNC_WORD    (8'hA5),
    .SYNC_TIMEOUT (64)
  ) dut (
    .IOCLK      (IOCLK),
    .RST        (RST),
    .START      (START),
    .ABORT      (ABORT),
    .CFG_VALID  (CFG_VALID),
    .CFG_DATA   (CFG_DATA),
    .CFG_READY  (CFG_READY),
    .TSMUX_OUT  (TSMUX_OUT),
    .DORREG_OUT (DORREG_OUT),
    .BUSY       (BUSY),
    .CFG_DONE   (CFG_DONE),
    .CFG_ERR    (CFG_ERR)
  );

  always #5 IOCLK = ~IOCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  // stream order: highest pad first, each as tsmux[1], tsmux[0], dorreg
  task automatic build_stream();
    stream.delete();
    for (int k = NUM_IO - 1; k >= 0; k--) begin
      stream.push_back(pad_ts[k][1]);
      stream.push_back(pad_ts[k][0]);
      stream.push_back(pad_dr[k]);
    end
  endtask

  task automatic rand_pads();
    for (int k = 0; k < NUM_IO; k++) begin
      pad_ts[k] = 2'($urandom_range(0, 3));
      pad_dr[k] = 1'($urandom_range(0, 1));
    end
    build_stream();
  endtask

  task automatic fill_pads(input logic [1:0] ts, input logic dr);
    for (int k = 0; k < NUM_IO; k++) begin
      pad_ts[k] = ts;
      pad_dr[k] = dr;
    end
    build_stream();
  endtask

  // call at a negedge; returns at the negedge after the accepting edge
  task automatic send_bit(input bit b);
    int n;
    CFG_VALID = 1'b1;
    CFG_DATA  = b;
    n = 0;
    while (!CFG_READY && n < 50) begin
      @(negedge IOCLK);
      n++;
    end
    checks++;
    if (!CFG_READY) begin
      errors++;
      $display("FAIL send_bit: ready=%0b required 1", CFG_READY);
    end
    @(negedge IOCLK);
    CFG_VALID = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_data(input bit gaps, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          CFG_DATA = 1'($urandom_range(0, 1));
          @(negedge IOCLK);
        end
      end
      send_bit(stream[i]);
    end
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge IOCLK);
    START = 1'b0;
  endtask

  // full load from START through commit, checking timing and atomicity
  task automatic run_load(input bit gaps, input bit noise, input string nm);
    logic [2*NUM_IO-1:0] ets;
    logic [NUM_IO-1:0]   edr;
    bit p;
    for (int k = 0; k < NUM_IO; k++) begin
      ets[2*k +: 2] = pad_ts[k];
      edr[k]        = pad_dr[k];
    end
    p = 1'b0;
    foreach (stream[i]) p ^= stream[i];
    pulse_start();
    checks++;
    if (BUSY !== 1'b1 || CFG_ERR !== 1'b0) begin
      errors++;
      $display("FAIL %s start: busy=%0b err=%0b required 1 0", nm, BUSY, CFG_ERR);
    end
    if (noise) begin
      send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    end
    send_byte(8'hA5);
    send_data(gaps, TOTAL / 2);
    checks++;
    if (TSMUX_OUT !== cur_ts || DORREG_OUT !== cur_dr) begin
      errors++;
      $display("FAIL %s midload: ts=%h dr=%h required %h %h",
               nm, TSMUX_OUT, DORREG_OUT, cur_ts, cur_dr);
    end
    for (int i = TOTAL / 2; i < TOTAL; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge IOCLK);
      send_bit(stream[i]);
    end
`ifdef IOCONFIG_PARITY_EN
    send_bit(p);
`endif
    checks++;
    if (CFG_DONE !== 1'b0 || TSMUX_OUT !== cur_ts || DORREG_OUT !== cur_dr) begin
      errors++;
      $display("FAIL %s precommit: done=%0b ts=%h dr=%h required 0 %h %h",
               nm, CFG_DONE, TSMUX_OUT, DORREG_OUT, cur_ts, cur_dr);
    end
    @(negedge IOCLK);
    checks++;
    if (CFG_DONE !== 1'b1) begin
      errors++;
      $display("FAIL %s done: done=%0b required 1", nm, CFG_DONE);
    end
    checks++;
    if (TSMUX_OUT !== ets || DORREG_OUT !== edr) begin
      errors++;
      $display("FAIL %s commit: ts=%h dr=%h required %h %h",
               nm, TSMUX_OUT, DORREG_OUT, ets, edr);
    end
    cur_ts = ets;
    cur_dr = edr;
    @(negedge IOCLK);
    checks++;
    if (CFG_DONE !== 1'b0 || BUSY !== 1'b0 || CFG_ERR !== 1'b0) begin
      errors++;
      $display("FAIL %s after: done=%0b busy=%0b err=%0b required 0 0 0",
               nm, CFG_DONE, BUSY, CFG_ERR);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge IOCLK);
    RST = 1'b0;
    repeat (10) @(negedge IOCLK);
    checks++;
    if (TSMUX_OUT !== '0 || DORREG_OUT !== '0) begin
      errors++;
      $display("FAIL reset outs: ts=%h dr=%h required 0 0", TSMUX_OUT, DORREG_OUT);
    end
    checks++;
    if (CFG_READY !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset ctl: ready=%0b busy=%0b required 0 0", CFG_READY, BUSY);
    end
    checks++;
    if (CFG_DONE !== 1'b0 || CFG_ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: done=%0b err=%0b required 0 0", CFG_DONE, CFG_ERR);
    end
  endtask

  task automatic test_basic();
    fill_pads(2'b01, 1'b0);
    run_load(1'b0, 1'b0, "basic");
    checks++;
    if (TSMUX_OUT !== 20'h55555 || DORREG_OUT !== 10'h000) begin
      errors++;
      $display("FAIL basic const: ts=%h dr=%h required 55555 000", TSMUX_OUT, DORREG_OUT);
    end
  endtask

  task automatic test_sync_noise();
    fill_pads(2'b11, 1'b1);
    run_load(1'b0, 1'b1, "noise");
    checks++;
    if (TSMUX_OUT !== 20'hFFFFF || DORREG_OUT !== 10'h3FF) begin
      errors++;
      $display("FAIL noise const: ts=%h dr=%h required fffff 3ff", TSMUX_OUT, DORREG_OUT);
    end
  endtask

  task automatic test_timeout();
    pulse_start();
    repeat (63) send_bit(1'b0);
    checks++;
    if (CFG_ERR !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL timeout early: err=%0b busy=%0b required 0 1", CFG_ERR, BUSY);
    end
    send_bit(1'b0);
    checks++;
    if (CFG_ERR !== 1'b1 || BUSY !== 1'b0 || CFG_READY !== 1'b0) begin
      errors++;
      $display("FAIL timeout: err=%0b busy=%0b ready=%0b required 1 0 0",
               CFG_ERR, BUSY, CFG_READY);
    end
    checks++;
    if (TSMUX_OUT !== cur_ts || DORREG_OUT !== cur_dr) begin
      errors++;
      $display("FAIL timeout outs: ts=%h dr=%h required %h %h",
               TSMUX_OUT, DORREG_OUT, cur_ts, cur_dr);
    end
    rand_pads();
    run_load(1'b0, 1'b0, "after_err");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      rand_pads();
      run_load(1'b1, 1'b0, "backpressure");
    end
  endtask

  task automatic test_abort();
    rand_pads();
    pulse_start();
    send_byte(8'hA5);
    send_data(1'b0, 15);
    ABORT     = 1'b1;
    CFG_VALID = 1'b1;
    CFG_DATA  = 1'b1;
    @(negedge IOCLK);
    ABORT     = 1'b0;
    CFG_VALID = 1'b0;
    checks++;
    if (BUSY !== 1'b0 || CFG_ERR !== 1'b0 || CFG_READY !== 1'b0) begin
      errors++;
      $display("FAIL abort: busy=%0b err=%0b ready=%0b required 0 0 0",
               BUSY, CFG_ERR, CFG_READY);
    end
    repeat (3) @(negedge IOCLK);
    checks++;
    if (CFG_DONE !== 1'b0 || TSMUX_OUT !== cur_ts || DORREG_OUT !== cur_dr) begin
      errors++;
      $display("FAIL abort outs: done=%0b ts=%h dr=%h required 0 %h %h",
               CFG_DONE, TSMUX_OUT, DORREG_OUT, cur_ts, cur_dr);
    end
  endtask

  task automatic test_reset_midload();
    rand_pads();
    pulse_start();
    send_byte(8'hA5);
    send_data(1'b0, 20);
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (TSMUX_OUT !== '0 || DORREG_OUT !== '0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL async reset: ts=%h dr=%h busy=%0b required 0 0 0",
               TSMUX_OUT, DORREG_OUT, BUSY);
    end
    @(negedge IOCLK);
    RST = 1'b0;
    cur_ts = '0;
    cur_dr = '0;
    @(negedge IOCLK);
    rand_pads();
    run_load(1'b0, 1'b0, "post_reset");
  endtask

`ifdef IOCONFIG_PARITY_EN
  task automatic test_parity_err();
    bit p;
    rand_pads();
    p = 1'b0;
    foreach (stream[i]) p ^= stream[i];
    pulse_start();
    send_byte(8'hA5);
    send_data(1'b0, TOTAL);
    send_bit(~p);
    checks++;
    if (CFG_ERR !== 1'b1 || CFG_DONE !== 1'b0) begin
      errors++;
      $display("FAIL parity err: err=%0b done=%0b required 1 0", CFG_ERR, CFG_DONE);
    end
    @(negedge IOCLK);
    checks++;
    if (CFG_DONE !== 1'b0 || TSMUX_OUT !== cur_ts || DORREG_OUT !== cur_dr) begin
      errors++;
      $display("FAIL parity outs: done=%0b ts=%h dr=%h required 0 %h %h",
               CFG_DONE, TSMUX_OUT, DORREG_OUT, cur_ts, cur_dr);
    end
    rand_pads();
    run_load(1'b0, 1'b0, "parity_recover");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_sync_noise();
    test_timeout();
    test_back_to_back();
    test_abort();
    test_reset_midload();
`ifdef IOCONFIG_PARITY_EN
    test_parity_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
